// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : 8-digit multiplexed seven-segment scanner with blanking gap and
//            frame-synchronous double-buffered display data.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_on,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        frame_start
);

    localparam int c_cnt_max = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int c_cnt_w   = (c_cnt_max <= 2) ? 1 : $clog2(c_cnt_max);
    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam bit c_no_gap = (BLANK_CYC == 0);

    typedef enum logic [0:0] {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    state_t              r_state, w_next_state;
    logic [2:0]          r_idx, w_next_idx;
    logic [c_cnt_w-1:0]  r_cnt, w_next_cnt;
    logic                w_enter_show;
    logic                w_frame_begin;

    logic [31:0]         r_sh_dig, r_act_dig;
    logic [7:0]          r_sh_dp, r_act_dp;
    logic [7:0]          r_sh_on, r_act_on;

    logic [7:0]          w_sel;
    logic [6:0]          w_hex;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BLANK;
            r_idx   <= 3'd7;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt + 1'b1;
        w_enter_show = 1'b0;
        case (r_state)
            S_SHOW: begin
                if (r_cnt == c_show_last) begin
                    w_next_cnt = '0;
                    if (c_no_gap) begin
                        w_next_idx   = r_idx + 3'd1;
                        w_enter_show = 1'b1;
                    end else begin
                        w_next_state = S_BLANK;
                    end
                end
            end
            default: begin
                if (r_cnt == c_blank_last) begin
                    w_next_state = S_SHOW;
                    w_next_idx   = r_idx + 3'd1;
                    w_next_cnt   = '0;
                    w_enter_show = 1'b1;
                end
            end
        endcase
    end

    assign w_frame_begin = w_enter_show && (w_next_idx == 3'd0);

    // Copy samples the pre-edge shadow, so a coincident load lands next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_dig  <= '0;
            r_sh_dp   <= '0;
            r_sh_on   <= '0;
            r_act_dig <= '0;
            r_act_dp  <= '0;
            r_act_on  <= '0;
        end else begin
            if (load) begin
                r_sh_dig <= digits_in;
                r_sh_dp  <= dp_in;
                r_sh_on  <= digit_on;
            end
            if (w_frame_begin) begin
                r_act_dig <= r_sh_dig;
                r_act_dp  <= r_sh_dp;
                r_act_on  <= r_sh_on;
            end
        end
    end

    assign w_sel = 8'h01 << r_idx;
    assign w_hex = hex7(r_act_dig[{r_idx, 2'b00} +: 4]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_en      <= '0;
            seg_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_begin;
            if ((r_state == S_SHOW) && r_act_on[r_idx]) begin
                seg_en  <= w_sel;
                seg_out <= {w_hex, r_act_dp[r_idx]};
            end else begin
                seg_en  <= '0;
                seg_out <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Self-checking bench; a gapped (4/2) and a gapless (4/0) instance
//            share stimulus and are compared to a timeline-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_scan = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_on = '0;

    logic [7:0]  a_en, a_out, b_en, b_out;
    logic        a_fs, b_fs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(c_scan), .BLANK_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .digit_on(digit_on), .seg_en(a_en), .seg_out(a_out), .frame_start(a_fs)
    );

    seg7_scan_driver #(.SCAN_DIV(c_scan), .BLANK_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .digit_on(digit_on), .seg_en(b_en), .seg_out(b_out), .frame_start(b_fs)
    );

    logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Model: p = clock edges since reset release; data held per instance.
    int          p;
    int          blank_of [2] = '{2, 0};
    logic [31:0] sh_dig;
    logic [7:0]  sh_dp, sh_on;
    logic [31:0] act_dig [2];
    logic [7:0]  act_dp [2];
    logic [7:0]  act_on [2];

    function automatic int first_fs(input int b);
        return (b == 0) ? 1 : b;
    endfunction

    function automatic bit is_fs(input int q, input int b);
        int p0 = first_fs(b);
        return (q >= p0) && (((q - p0) % (8 * (c_scan + b))) == 0);
    endfunction

    // Which digit (if any) is in its lit slot after edge q.
    function automatic void slot(input int q, input int b, output bit show, output int d);
        int p0 = first_fs(b);
        int o;
        show = 1'b0;
        d    = 0;
        if (q >= p0) begin
            o    = (q - p0) % (8 * (c_scan + b));
            d    = o / (c_scan + b);
            show = (o % (c_scan + b)) < c_scan;
        end
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] e_en [2];
        logic [7:0] e_out [2];
        logic       e_fs [2];
        bit         show;
        int         d;
        logic [3:0] nib;
        for (int u = 0; u < 2; u++) begin
            slot(p, blank_of[u], show, d);
            e_en[u]  = '0;
            e_out[u] = '0;
            if (show && act_on[u][d]) begin
                nib      = act_dig[u][4*d +: 4];
                e_en[u]  = 8'h01 << d;
                e_out[u] = {hex_tab[nib], act_dp[u][d]};
            end
            e_fs[u] = is_fs(p + 1, blank_of[u]);
            if (e_fs[u]) begin
                act_dig[u] = sh_dig;
                act_dp[u]  = sh_dp;
                act_on[u]  = sh_on;
            end
        end
        if (load) begin
            sh_dig = digits_in;
            sh_dp  = dp_in;
            sh_on  = digit_on;
        end
        p++;
        @(posedge clk);
        #1;
        check8("a_seg_en", a_en, e_en[0]);
        check8("a_seg_out", a_out, e_out[0]);
        check8("a_frame_start", {7'd0, a_fs}, {7'd0, e_fs[0]});
        check8("b_seg_en", b_en, e_en[1]);
        check8("b_seg_out", b_out, e_out[1]);
        check8("b_frame_start", {7'd0, b_fs}, {7'd0, e_fs[1]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_step(input logic [31:0] dig, input logic [7:0] dp, input logic [7:0] on);
        digits_in = dig;
        dp_in     = dp;
        digit_on  = on;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    // Asynchronous clear is checked mid-cycle, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check8("rst_async_a_en", a_en, 8'h00);
        check8("rst_async_a_out", a_out, 8'h00);
        check8("rst_async_b_en", b_en, 8'h00);
        check8("rst_async_b_out", b_out, 8'h00);
        @(posedge clk);
        #1;
        check8("rst_held_a_fs", {7'd0, a_fs}, 8'h00);
        check8("rst_held_b_en", b_en, 8'h00);
        rst    = 1'b0;
        p      = 0;
        sh_dig = '0;
        sh_dp  = '0;
        sh_on  = '0;
        for (int u = 0; u < 2; u++) begin
            act_dig[u] = '0;
            act_dp[u]  = '0;
            act_on[u]  = '0;
        end
    endtask

    initial begin
        bit found;
        bit show;
        int d;

        #1;
        do_reset();
        run(150);

        load_step(32'h76543210, 8'h00, 8'hFF);
        run(100);

        load_step(32'hFEDCBA98, 8'h01, 8'h0F);
        run(100);

        // Mid-frame load, then a load sampled on the copy edge itself.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (((p - 2) % 48) == 20) found = 1'b1;
            else step();
        end
        checks++;
        assert (found) else begin errors++; $error("FAIL midframe_wait timeout observed=0 expected=1"); end
        load_step($urandom, 8'($urandom), 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (is_fs(p + 1, 2)) found = 1'b1;
            else step();
        end
        checks++;
        assert (found) else begin errors++; $error("FAIL copyedge_wait timeout observed=0 expected=1"); end
        load_step(32'h13579BDF, 8'h80, 8'hFF);
        run(100);

        // Reset while digit 3 of the gapped instance is lit.
        load_step(32'h12345678, 8'hAA, 8'hFF);
        run(60);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            slot(p - 1, 2, show, d);
            if (show && d == 3 && a_en == 8'h08) found = 1'b1;
            else step();
        end
        checks++;
        assert (found) else begin errors++; $error("FAIL digit3_wait timeout observed=0 expected=1"); end
        do_reset();
        run(60);

        for (int k = 0; k < 20; k++) begin
            load_step($urandom, 8'($urandom), 8'($urandom));
            run(int'($urandom_range(1, 40)));
        end
        run(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
